// File: rtl/core_run_ctrl.sv
// core_run_ctrl: holds N_CORES cores in reset, releases them (optionally
// staggered), runs them until all report done or the cycle budget expires.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_start            one-cycle restart request (any state)
//   i_halt             pause run-cycle counting while high (RUN only)
//   i_core_done        per-core completion level, latched sticky in RUN
//   o_core_rst         active-high reset to each core
//   o_running          high in RUN
//   o_done, o_timeout  completion / budget-expired status
//   o_cycles           run cycles elapsed, excluding halted cycles
module core_run_ctrl #(
  parameter int N_CORES      = 1,
  parameter int RST_CYCLES   = 5,
  parameter int STAGGER      = 0,
  parameter int RUN_CYCLES   = 30,
  parameter int CNT_WIDTH    = 16,
  parameter bit HOLD_ON_DONE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_halt,
  input  logic [N_CORES-1:0]   i_core_done,
  output logic [N_CORES-1:0]   o_core_rst,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_cycles
);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_REL =
    CNT_WIDTH'(RST_CYCLES + (N_CORES - 1) * STAGGER);
  localparam logic [CNT_WIDTH-1:0] RUN_LIM =
    CNT_WIDTH'(RUN_CYCLES);
  localparam bit HAS_LIM = (RUN_CYCLES != 0);

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_hold_cnt;
  logic [N_CORES-1:0]   r_core_rst;
  logic                 r_running;
  logic                 r_done;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic [N_CORES-1:0]   r_seen;

  logic [CNT_WIDTH-1:0] w_hold_nxt;
  logic [N_CORES-1:0]   w_rel;
  logic                 w_last_rel;
  logic [CNT_WIDTH-1:0] w_cyc_inc;
  logic [CNT_WIDTH-1:0] w_cyc_nxt;
  logic [N_CORES-1:0]   w_seen;
  logic                 w_all_done;
  logic                 w_tmo;

  assign w_hold_nxt = r_hold_cnt + 1'b1;
  assign w_last_rel = (w_hold_nxt == LAST_REL);

  // Core k leaves reset once the hold count reaches its own release edge.
  for (genvar k = 0; k < N_CORES; k++) begin : g_rel
    localparam logic [CNT_WIDTH-1:0] THR =
      CNT_WIDTH'(RST_CYCLES + k * STAGGER);
    assign w_rel[k] = (w_hold_nxt >= THR);
  end

  // Saturating run counter; a halted cycle is simply not counted.
  assign w_cyc_inc  = (&r_cycles) ? r_cycles : r_cycles + 1'b1;
  assign w_cyc_nxt  = i_halt ? r_cycles : w_cyc_inc;
  assign w_seen     = r_seen | i_core_done;
  assign w_all_done = &w_seen;
  assign w_tmo      = HAS_LIM && !i_halt && (w_cyc_inc == RUN_LIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= '0;
      r_core_rst <= '1;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
      r_seen     <= '0;
    end else if (i_start) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= '0;
      r_core_rst <= '1;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
      r_seen     <= '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_hold_cnt <= w_hold_nxt;
          r_core_rst <= ~w_rel;
          if (w_last_rel) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          r_seen   <= w_seen;
          r_cycles <= w_cyc_nxt;
          // Completion takes priority over a same-edge timeout.
          if (w_all_done) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            if (HOLD_ON_DONE) r_core_rst <= '1;
          end else if (w_tmo) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_timeout <= 1'b1;
            if (HOLD_ON_DONE) r_core_rst <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_core_rst = r_core_rst;
  assign o_running  = r_running;
  assign o_done     = r_done;
  assign o_timeout  = r_timeout;
  assign o_cycles   = r_cycles;

endmodule
